// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: replays a solved knight's tour as vertical/horizontal move commands, else forwards UART commands
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp
);
    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;
    state_t state;
    logic [7:0] low;
    logic up, dy2, right, dx2, last;
    logic [15:0] vcmd, hcmd;
    // isolate the lowest set bit so multi-hot moves resolve to one move
    assign low   = move & (~move + 8'd1);
    assign up    = |(low & 8'b1000_0111);
    assign dy2   = |(low & 8'b0011_0011);
    assign right = |(low & 8'b1110_0001);
    assign dx2   = |(low & 8'b1100_1100);
    assign vcmd  = {4'h2, up ? 8'h00 : 8'h7F, dy2 ? 4'd2 : 4'd1};
    assign hcmd  = {4'h3, right ? 8'hBF : 8'h3F, dx2 ? 4'd2 : 4'd1};
    assign last  = mv_indx == IDX_W'(NUM_MOVES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            case (state)
                IDLE:    if (start_tour) begin
                             mv_indx <= '0;
                             state   <= VERT;
                         end
                VERT:    if (move == 8'h00) state <= IDLE;
                         else if (clr_cmd_rdy) state <= WAIT_V;
                WAIT_V:  if (send_resp) state <= HORZ;
                HORZ:    if (clr_cmd_rdy) state <= WAIT_H;
                WAIT_H:  if (send_resp) begin
                             if (last) state <= IDLE;
                             else begin
                                 mv_indx <= mv_indx + 1'b1;
                                 state   <= VERT;
                             end
                         end
                default: state <= IDLE;
            endcase
        end
    end
    // outputs are combinational so UART passthrough and reset take effect in the same cycle
    always_comb begin
        cmd     = state == IDLE ? cmd_UART : (state == VERT || state == WAIT_V) ? vcmd : hcmd;
        cmd_rdy = state == IDLE ? cmd_rdy_UART : state == VERT ? |move : state == HORZ;
        resp    = (state == IDLE || (state == WAIT_H && last)) ? 8'hA5 : 8'h5A;
    end
endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb_tour_cmd_seq: directed bench with a command scoreboard and a solver model driving move from mv_indx
module tb_tour_cmd_seq;
    logic clk = 0, rst = 0, start_tour = 0, cmd_rdy_UART = 0, clr_cmd_rdy = 0, send_resp = 0;
    logic [7:0] move;
    logic [4:0] mv_indx;
    logic [15:0] cmd_UART = 16'h0, cmd;
    logic cmd_rdy;
    logic [7:0] resp;
    logic [7:0] tour [24];
    logic [15:0] sb [$];
    int zero_at = -1, checks = 0, errors = 0, n5a = 0;

    tour_cmd_seq #(.NUM_MOVES(24), .IDX_W(5)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp)
    );

    always #5 clk = ~clk;
    always_comb move = (int'(mv_indx) == zero_at) ? 8'h00 : tour[mv_indx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cmd(logic [7:0] m, bit horz);
        int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
        int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        int b, d;
        b = 0;
        while (b < 7 && !m[b]) b++;
        d = horz ? dxs[b] : dys[b];
        if (horz) return {4'h3, d > 0 ? 8'hBF : 8'h3F, 4'(d < 0 ? -d : d)};
        return {4'h2, d > 0 ? 8'h00 : 8'h7F, 4'(d < 0 ? -d : d)};
    endfunction

    // mode: 0 normal, 1 start_tour in wait, 2 send_resp before clr, 3 clr+send_resp together
    task automatic do_leg(logic [7:0] exp_resp, int mode, int idx);
        logic [15:0] e;
        e = sb.pop_front();
        chk("leg_rdy", 32'(cmd_rdy), 1);
        chk("leg_cmd", 32'(cmd), 32'(e));
        if (mode == 2) begin
            send_resp = 1;
            tick();
            send_resp = 0;
            chk("resp_ign_rdy", 32'(cmd_rdy), 1);
            chk("resp_ign_cmd", 32'(cmd), 32'(e));
        end
        clr_cmd_rdy = 1;
        if (mode == 3) send_resp = 1;
        tick();
        clr_cmd_rdy = 0;
        send_resp = 0;
        chk("wait_rdy0", 32'(cmd_rdy), 0);
        chk("wait_cmd_held", 32'(cmd), 32'(e));
        if (mode == 1) begin
            start_tour = 1;
            tick();
            start_tour = 0;
            chk("start_ign_rdy", 32'(cmd_rdy), 0);
            chk("start_ign_idx", 32'(mv_indx), 32'(idx));
        end
        chk("resp", 32'(resp), 32'(exp_resp));
        if (resp == 8'h5A) n5a++;
        send_resp = 1;
        tick();
        send_resp = 0;
    endtask

    task automatic run_move(int i, int mode_v);
        logic [15:0] cv [3] = '{16'h2002, 16'h27F1, 16'h27F1};
        logic [15:0] ch [3] = '{16'h3BF1, 16'h33F2, 16'h3BF2};
        sb.push_back(i < 3 ? cv[i] : exp_cmd(tour[i], 0));
        sb.push_back(i < 3 ? ch[i] : exp_cmd(tour[i], 1));
        do_leg(8'h5A, mode_v, i);
        do_leg(i == 23 ? 8'hA5 : 8'h5A, 0, i);
        chk("mv_indx", 32'(mv_indx), i == 23 ? 32'd23 : 32'(i + 1));
    endtask

    task automatic begin_tour();
        sb.delete();
        start_tour = 1;
        tick();
        start_tour = 0;
        chk("start_idx0", 32'(mv_indx), 0);
    endtask

    initial begin
        for (int i = 0; i < 24; i++) tour[i] = 8'h01 << (i % 8);
        tour[0] = 8'h01; tour[1] = 8'h08; tour[2] = 8'h40;
        tour[3] = 8'h68; tour[11] = 8'hC0; tour[19] = 8'h81;
        // reset state with UART path active
        cmd_UART = 16'h2BF3;
        cmd_rdy_UART = 1;
        #2 rst = 1;
        #1;
        chk("rst_cmd", 32'(cmd), 32'h2BF3);
        chk("rst_rdy", 32'(cmd_rdy), 1);
        chk("rst_resp", 32'(resp), 32'hA5);
        chk("rst_idx", 32'(mv_indx), 0);
        tick();
        rst = 0;
        tick();
        chk("pass_cmd", 32'(cmd), 32'h2BF3);
        chk("pass_rdy", 32'(cmd_rdy), 1);
        cmd_rdy_UART = 0;
        cmd_UART = 16'h3001;
        #1;
        chk("pass_rdy0", 32'(cmd_rdy), 0);
        chk("pass_cmd2", 32'(cmd), 32'h3001);
        // full tour with UART asserting throughout
        cmd_rdy_UART = 1;
        cmd_UART = 16'hFFFF;
        n5a = 0;
        begin_tour();
        chk("tour_resp5a", 32'(resp), 32'h5A);
        for (int i = 0; i < 24; i++) run_move(i, i == 4 ? 1 : i == 7 ? 2 : i == 8 ? 3 : 0);
        chk("n5a", 32'(n5a), 47);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("done_idx", 32'(mv_indx), 23);
        chk("done_resp", 32'(resp), 32'hA5);
        chk("done_pass_rdy", 32'(cmd_rdy), 1);
        chk("done_pass_cmd", 32'(cmd), 32'hFFFF);
        // abort on empty move at index 5
        cmd_rdy_UART = 0;
        zero_at = 5;
        begin_tour();
        for (int i = 0; i < 5; i++) run_move(i, 0);
        chk("abort_rdy0", 32'(cmd_rdy), 0);
        tick();
        chk("abort_idx", 32'(mv_indx), 5);
        chk("abort_resp", 32'(resp), 32'hA5);
        cmd_rdy_UART = 1;
        cmd_UART = 16'h2BF3;
        #1;
        chk("abort_pass_rdy", 32'(cmd_rdy), 1);
        chk("abort_pass_cmd", 32'(cmd), 32'h2BF3);
        zero_at = -1;
        // reset in WAIT_H at index 10
        cmd_rdy_UART = 0;
        begin_tour();
        for (int i = 0; i < 10; i++) run_move(i, 0);
        sb.push_back(exp_cmd(tour[10], 0));
        do_leg(8'h5A, 0, 10);
        chk("h10_cmd", 32'(cmd), 32'(exp_cmd(tour[10], 1)));
        clr_cmd_rdy = 1;
        tick();
        clr_cmd_rdy = 0;
        chk("h10_wait_rdy0", 32'(cmd_rdy), 0);
        cmd_rdy_UART = 1;
        rst = 1;
        #1;
        chk("mrst_rdy", 32'(cmd_rdy), 1);
        chk("mrst_idx", 32'(mv_indx), 0);
        chk("mrst_resp", 32'(resp), 32'hA5);
        tick();
        rst = 0;
        cmd_rdy_UART = 0;
        begin_tour();
        run_move(0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
